// File: rtl/layer1_pkg.sv
// Shared widths and types for the first classifier layer.
package layer1_pkg;

  localparam int unsigned W_SIZE   = 8;
  localparam int unsigned ACC_SIZE = 2 * W_SIZE;
  localparam int unsigned N_LANES  = 5;

  typedef logic signed [W_SIZE-1:0]   weight_t;
  typedef logic signed [ACC_SIZE-1:0] acc_t;

endpackage

// File: rtl/layer1_mac_lane.sv
// One signed multiply-accumulate lane gated by a binary pixel.
module layer1_mac_lane
  import layer1_pkg::*;
#(
  parameter int unsigned Size = W_SIZE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [Size-1:0]     weight,
  input  logic                       mask,
  input  logic                       en,
  input  logic                       start,
  output logic signed [2*Size-1:0]   acc
);

  logic signed [2*Size-1:0] prod;
  logic signed [2*Size-1:0] base;
  logic signed [2*Size-1:0] acc_d;
  logic signed [2*Size-1:0] acc_q;

  // Gate the sign-extended weight by the pixel; the first step of a frame discards the old sum.
  always_comb begin
    prod  = '0;
    base  = acc_q;
    acc_d = acc_q;
    if (mask) begin
      prod = {{Size{weight[Size-1]}}, weight};
    end
    if (start) begin
      base = '0;
    end
    if (en) begin
      acc_d = base + prod;
    end
  end

  // Accumulator register; wraps modulo 2^(2*Size).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/layer1_5_multiply.sv
// Five-lane first-layer MAC engine with frame start/end detection.
module layer1_5_multiply
  import layer1_pkg::*;
#(
  parameter int unsigned SIZE = W_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [SIZE-1:0]   vector_input_1,
  input  logic signed [SIZE-1:0]   vector_input_2,
  input  logic signed [SIZE-1:0]   vector_input_3,
  input  logic signed [SIZE-1:0]   vector_input_4,
  input  logic signed [SIZE-1:0]   vector_input_5,
  input  logic                     mask_input,
  input  logic                     load,
  input  logic                     accumulate,
  output logic signed [2*SIZE-1:0] accumulate_1,
  output logic signed [2*SIZE-1:0] accumulate_2,
  output logic signed [2*SIZE-1:0] accumulate_3,
  output logic signed [2*SIZE-1:0] accumulate_4,
  output logic signed [2*SIZE-1:0] accumulate_5,
  output logic                     accumulate_signal
);

  logic signed [SIZE-1:0]   weights [N_LANES];
  logic signed [2*SIZE-1:0] sums    [N_LANES];

  logic acc_prev_d, acc_prev_q;
  logic eof_d, eof_q;
  logic start;
  logic step_en;

  assign weights[0] = vector_input_1;
  assign weights[1] = vector_input_2;
  assign weights[2] = vector_input_3;
  assign weights[3] = vector_input_4;
  assign weights[4] = vector_input_5;

  // Frame control: rising accumulate starts a frame, falling accumulate pulses end-of-frame.
  always_comb begin
    acc_prev_d = accumulate;
    start      = accumulate & ~acc_prev_q;
    step_en    = load & accumulate;
    eof_d      = acc_prev_q & ~accumulate;
  end

  // Frame-control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_prev_q <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      acc_prev_q <= acc_prev_d;
      eof_q      <= eof_d;
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    layer1_mac_lane #(
      .Size (SIZE)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .weight (weights[k]),
      .mask   (mask_input),
      .en     (step_en),
      .start  (start),
      .acc    (sums[k])
    );
  end

  assign accumulate_1      = sums[0];
  assign accumulate_2      = sums[1];
  assign accumulate_3      = sums[2];
  assign accumulate_4      = sums[3];
  assign accumulate_5      = sums[4];
  assign accumulate_signal = eof_q;

endmodule

// File: tb/tb_layer1_5_multiply.sv
// Directed self-checking bench for layer1_5_multiply.
module tb_layer1_5_multiply;

  logic        clk;
  logic        reset;
  logic [7:0]  w1, w2, w3, w4, w5;
  logic        mask_input;
  logic        load;
  logic        accumulate;
  logic [15:0] a1, a2, a3, a4, a5;
  logic        sig;

  int n_cmp;
  int n_bad;

  layer1_5_multiply #(
    .SIZE (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .vector_input_1    (w1),
    .vector_input_2    (w2),
    .vector_input_3    (w3),
    .vector_input_4    (w4),
    .vector_input_5    (w5),
    .mask_input        (mask_input),
    .load              (load),
    .accumulate        (accumulate),
    .accumulate_1      (a1),
    .accumulate_2      (a2),
    .accumulate_3      (a3),
    .accumulate_4      (a4),
    .accumulate_5      (a5),
    .accumulate_signal (sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Apply inputs, then wait one rising edge and settle.
  task automatic step(input logic ld, input logic ac, input logic m);
    load       = ld;
    accumulate = ac;
    mask_input = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    w1 = 8'd0; w2 = 8'd0; w3 = 8'd0; w4 = 8'd0; w5 = 8'd0;
    mask_input = 1'b0;
    load       = 1'b0;
    accumulate = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a1", a1, 16'h0000);
    check("rst_sig", {15'd0, sig}, 16'h0000);
    #3 reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // Basic frame: mask 1,1,0,1.
    w1 = 8'd3; w2 = 8'hFE; w3 = 8'h10; w4 = 8'h81; w5 = 8'h01;
    step(1'b1, 1'b1, 1'b1);
    check("basic_lat_a1", a1, 16'h0003);
    check("basic_lat_sig", {15'd0, sig}, 16'h0000);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("basic_a1", a1, 16'h0009);
    check("basic_a2", a2, 16'hFFFA);
    check("basic_a3", a3, 16'h0030);
    check("basic_a4", a4, 16'hFE83);
    check("basic_a5", a5, 16'h0003);

    // End of frame with load still high.
    step(1'b1, 1'b0, 1'b1);
    check("eof_pulse", {15'd0, sig}, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1);
      check("eof_clear", {15'd0, sig}, 16'h0000);
      check("eof_hold_a1", a1, 16'h0009);
      check("eof_hold_a2", a2, 16'hFFFA);
    end

    // Restart: single-step frame overwrites the old sum.
    w1 = 8'd5;
    step(1'b1, 1'b1, 1'b1);
    check("restart_a1", a1, 16'h0005);
    check("restart_a2", a2, 16'hFFFE);
    step(1'b1, 1'b0, 1'b0);
    check("restart_pulse", {15'd0, sig}, 16'h0001);

    // Stall mid-frame.
    w1 = 8'd2;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("stall_pre_a1", a1, 16'h0004);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1);
      check("stall_hold_a1", a1, 16'h0004);
      check("stall_nopulse", {15'd0, sig}, 16'h0000);
    end
    step(1'b1, 1'b1, 1'b1);
    check("stall_resume_a1", a1, 16'h0006);
    step(1'b0, 1'b0, 1'b0);
    check("stall_eof", {15'd0, sig}, 16'h0001);

    // load=1 with accumulate=0 never updates.
    step(1'b1, 1'b0, 1'b1);
    check("idle_load_a1", a1, 16'h0006);

    // Extremes over 256 terms.
    w1 = 8'h7F; w2 = 8'h80; w3 = 8'hFF; w4 = 8'h00; w5 = 8'h01;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b1, 1'b1);
    end
    check("ext_a1", a1, 16'h7F00);
    check("ext_a2", a2, 16'h8000);
    check("ext_a3", a3, 16'hFF00);
    check("ext_a4", a4, 16'h0000);
    check("ext_a5", a5, 16'h0100);
    step(1'b0, 1'b0, 1'b0);
    check("ext_eof", {15'd0, sig}, 16'h0001);

    // Asynchronous reset mid-frame, between clock edges.
    w1 = 8'd3; w2 = 8'hFE;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("pre_rst_a1", a1, 16'h0006);
    #2 reset = 1'b0;
    #1;
    check("async_rst_a1", a1, 16'h0000);
    check("async_rst_a2", a2, 16'h0000);
    check("async_rst_sig", {15'd0, sig}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    // accumulate stays high through reset; first edge after must start a fresh frame.
    w1 = 8'd5;
    step(1'b1, 1'b1, 1'b1);
    check("post_rst_a1", a1, 16'h0005);
    check("post_rst_a2", a2, 16'hFFFE);
    step(1'b0, 1'b0, 1'b0);
    check("post_rst_eof", {15'd0, sig}, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
